kernel_stream_harness: RTL and testbench

Parametrised run-control and output-compaction harness for HLS kernels on the board-level power bench. It synchronises an asynchronous start request, issues ap_start/ap_ready handshakes for a programmable number of back-to-back kernel runs, and XOR-folds NUM_CH output streams into a narrow registered data_out/data_valid pair. It also accumulates a rotating signature over the whole request. It sits between the kernel instance and the top-level pins, replacing per-benchmark hand-written start and output logic.

---
 rtl/kernel_stream_harness.sv | 169 ++++++++++++++++
 tb/tb_kernel_stream_harness.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kernel_stream_harness.sv
// Run-control and output-compaction harness for HLS kernels: synchronised start request,
// ap_start/ap_ready/ap_done sequencing over RUN_NUM runs, and an XOR fold of NUM_CH streams.
module kernel_stream_harness #(
  parameter int NUM_CH      = 1,
  parameter int DIN_WIDTH   = 32,
  parameter int OUT_WIDTH   = 4,
  parameter int RUN_NUM     = 8,
  parameter int SYNC_STAGES = 3
) (
  input  logic                        ap_clk,
  input  logic                        ap_rst_n,
  input  logic                        start_req,
  output logic                        ap_start,
  input  logic                        ap_ready,
  input  logic                        ap_done,
  input  logic [NUM_CH*DIN_WIDTH-1:0] ch_din,
  input  logic [NUM_CH-1:0]           ch_write,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic                        data_valid,
  output logic [OUT_WIDTH-1:0]        signature,
  output logic [15:0]                 run_cnt,
  output logic                        busy,
  output logic                        all_done
);

  localparam int          SLICES     = DIN_WIDTH / OUT_WIDTH;
  localparam logic [15:0] RUN_TARGET = 16'(RUN_NUM);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_WAIT
  } state_t;

  // Start request synchroniser and rising-edge detect
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   req_prev_q;
  logic                   req_sync;
  logic                   req_rise;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      sync_q     <= '0;
      req_prev_q <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], start_req};
      req_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign req_sync = sync_q[SYNC_STAGES-1];
  assign req_rise = req_sync & ~req_prev_q;

  // Run-control FSM
  state_t      state_q, state_d;
  logic        done_evt;
  logic        run_limit_hit;
  logic        req_accept;
  logic [15:0] run_cnt_inc;

  assign run_cnt_inc   = (run_cnt == 16'hFFFF) ? run_cnt : run_cnt + 16'd1;
  assign run_limit_hit = (RUN_NUM != 0) && (run_cnt_inc == RUN_TARGET);
  assign req_accept    = (state_q == ST_IDLE) && req_rise;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    done_evt = 1'b0;
    case (state_q)
      ST_IDLE:  if (req_rise) state_d = ST_START;
      ST_START: begin
        if (ap_ready) begin
          if (ap_done) done_evt = 1'b1;
          else         state_d  = ST_WAIT;
        end
      end
      ST_WAIT:  if (ap_done) done_evt = 1'b1;
      default:  state_d = ST_IDLE;
    endcase
    // A finished run either ends the request or immediately starts the next one
    if (done_evt) begin
      if (run_limit_hit)                  state_d = ST_IDLE;
      else if (RUN_NUM == 0 && !req_sync) state_d = ST_IDLE;
      else                                state_d = ST_START;
    end
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      state_q  <= ST_IDLE;
      ap_start <= 1'b0;
      run_cnt  <= '0;
      all_done <= 1'b0;
    end else begin
      state_q  <= state_d;
      ap_start <= (state_d == ST_START);
      if (req_accept) begin
        run_cnt  <= '0;
        all_done <= 1'b0;
      end else if (done_evt) begin
        run_cnt <= run_cnt_inc;
        if (run_limit_hit) all_done <= 1'b1;
      end
    end
  end

  assign busy = (state_q != ST_IDLE);

  // Fold stage 1: per-channel slice XOR, zero for idle channels
  logic [NUM_CH-1:0][OUT_WIDTH-1:0] fold_d, fold_q;
  logic                             v1_q;

  always_comb begin
    fold_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_write[k]) begin
        for (int s = 0; s < SLICES; s++) begin
          fold_d[k] = fold_d[k] ^ ch_din[k*DIN_WIDTH + s*OUT_WIDTH +: OUT_WIDTH];
        end
      end
    end
  end

  // Fold stage 2: cross-channel XOR
  logic [OUT_WIDTH-1:0] out_d;

  always_comb begin
    out_d = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      out_d = out_d ^ fold_q[k];
    end
    if (!v1_q) out_d = '0;
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      fold_q     <= '0;
      v1_q       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
    end else begin
      fold_q     <= fold_d;
      v1_q       <= |ch_write;
      data_out   <= out_d;
      data_valid <= v1_q;
    end
  end

  // Rotating signature; a single-bit signature has nothing to rotate
  logic [OUT_WIDTH-1:0] sig_rot;

  if (OUT_WIDTH == 1) begin : g_rot1
    assign sig_rot = signature;
  end else begin : g_rotn
    assign sig_rot = {signature[OUT_WIDTH-2:0], signature[OUT_WIDTH-1]};
  end

  always_ff @(posedge ap_clk) begin
    if (!ap_rst_n) begin
      signature <= '0;
    end else if (req_accept) begin
      signature <= '0;
    end else if (data_valid) begin
      signature <= sig_rot ^ data_out;
    end
  end

endmodule

// File: tb/tb_kernel_stream_harness.sv
// Self-checking bench: a counted-run instance (2 channels, RUN_NUM=3) with random fold traffic,
// and a free-running instance (RUN_NUM=0) for start_req drop and mid-run reset.
module tb_kernel_stream_harness;

  localparam int SYNC = 3;

  logic ap_clk = 1'b0;
  always #5 ap_clk = ~ap_clk;

  logic ap_rst_n;

  // Instance A: NUM_CH=2, RUN_NUM=3
  logic        a_start_req, a_ap_start, a_ap_ready, a_ap_done;
  logic [63:0] a_ch_din;
  logic [1:0]  a_ch_write;
  logic [3:0]  a_data_out, a_signature;
  logic        a_data_valid, a_busy, a_all_done;
  logic [15:0] a_run_cnt;

  // Instance B: NUM_CH=1, RUN_NUM=0 (free-running)
  logic        b_start_req, b_ap_start, b_ap_ready, b_ap_done;
  logic [31:0] b_ch_din;
  logic [0:0]  b_ch_write;
  logic [3:0]  b_data_out, b_signature;
  logic        b_data_valid, b_busy, b_all_done;
  logic [15:0] b_run_cnt;

  kernel_stream_harness #(
    .NUM_CH(2), .DIN_WIDTH(32), .OUT_WIDTH(4), .RUN_NUM(3), .SYNC_STAGES(SYNC)
  ) u_dut_a (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start_req(a_start_req),
    .ap_start(a_ap_start), .ap_ready(a_ap_ready), .ap_done(a_ap_done),
    .ch_din(a_ch_din), .ch_write(a_ch_write),
    .data_out(a_data_out), .data_valid(a_data_valid), .signature(a_signature),
    .run_cnt(a_run_cnt), .busy(a_busy), .all_done(a_all_done)
  );

  kernel_stream_harness #(
    .NUM_CH(1), .DIN_WIDTH(32), .OUT_WIDTH(4), .RUN_NUM(0), .SYNC_STAGES(SYNC)
  ) u_dut_b (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .start_req(b_start_req),
    .ap_start(b_ap_start), .ap_ready(b_ap_ready), .ap_done(b_ap_done),
    .ch_din(b_ch_din), .ch_write(b_ch_write),
    .data_out(b_data_out), .data_valid(b_data_valid), .signature(b_signature),
    .run_cnt(b_run_cnt), .busy(b_busy), .all_done(b_all_done)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference-model state
  int         edge_n   = 0;
  int         clr_edge = -1;
  logic       d1_v, exp_v;
  logic [3:0] d1_d, exp_d, exp_sig;
  bit         traffic  = 0;
  bit         ka_en    = 0;
  bit         kb_en    = 0;
  int         ka_cnt   = 0;
  int         kb_cnt   = 0;
  int         kb_ph    = 0;
  int         a_runs   = 0;
  int         b_runs   = 0;
  logic       a_start_pre;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] fold_word(input logic [31:0] w);
    logic [3:0] r;
    r = 4'h0;
    for (int i = 0; i < 8; i++) r = r ^ 4'((w >> (4 * i)) & 32'hF);
    return r;
  endfunction

  function automatic logic [3:0] rotl4(input logic [3:0] x);
    return 4'(((x << 1) | (x >> 3)) & 4'hF);
  endfunction

  // One clock: optional random traffic, model update, output checks, kernel emulation
  task automatic step();
    logic       cv, rst_now;
    logic [3:0] cd;
    if (traffic) begin
      a_ch_write = 2'($urandom_range(0, 3));
      a_ch_din   = {$urandom, $urandom};
    end
    cv = |a_ch_write;
    cd = 4'h0;
    if (a_ch_write[0]) cd = cd ^ fold_word(a_ch_din[31:0]);
    if (a_ch_write[1]) cd = cd ^ fold_word(a_ch_din[63:32]);
    rst_now     = ap_rst_n;
    a_start_pre = a_ap_start;
    @(posedge ap_clk);
    #1;
    edge_n++;
    if (!rst_now) begin
      d1_v = 0; d1_d = 0; exp_v = 0; exp_d = 0; exp_sig = 0;
    end else begin
      if (edge_n == clr_edge)  exp_sig = 4'h0;
      else if (exp_v)          exp_sig = rotl4(exp_sig) ^ exp_d;
      exp_v = d1_v; exp_d = d1_d;
      d1_v  = cv;   d1_d  = cd;
    end
    check("a_data_valid", a_data_valid, exp_v);
    check("a_data_out", a_data_out, exp_d);
    check("a_signature", a_signature, exp_sig);

    // Kernel A: ready and done together 10 cycles after it starts a run
    if (ka_en) begin
      if (a_ap_ready) begin
        a_runs += int'(a_start_pre);
        a_ap_ready = 0; a_ap_done = 0; ka_cnt = 0;
        check("a_run_cnt", a_run_cnt, a_runs);
        check("a_all_done", a_all_done, a_runs == 3);
      end else if (ka_cnt > 0) begin
        ka_cnt--;
        if (ka_cnt == 0) begin a_ap_ready = 1; a_ap_done = 1; end
      end else if (a_ap_start) begin
        ka_cnt = 10;
      end
    end

    // Kernel B: ready 2 cycles after start, done 5 cycles after ready
    if (kb_en) begin
      if (b_ap_done) begin
        b_ap_done = 0; b_runs++; kb_ph = 0;
        check("b_run_cnt", b_run_cnt, b_runs);
      end else if (b_ap_ready) begin
        b_ap_ready = 0; kb_cnt = 5; kb_ph = 2;
        check("b_start_fall", b_ap_start, 0);
      end else if (kb_ph == 2) begin
        kb_cnt--;
        if (kb_cnt == 0) b_ap_done = 1;
      end else if (kb_ph == 1) begin
        kb_cnt--;
        if (kb_cnt == 0) b_ap_ready = 1;
      end else if (b_ap_start) begin
        kb_ph = 1; kb_cnt = 2;
      end
    end
  endtask

  task automatic run_request_a();
    int guard;
    bit start_seen;
    a_runs      = 0;
    clr_edge    = edge_n + 1 + SYNC;
    a_start_req = 1;
    for (int i = 0; i < SYNC; i++) begin
      step();
      check("a_start_latency", a_ap_start, 0);
    end
    step();
    check("a_start_rise", a_ap_start, 1);
    check("a_busy_rise", a_busy, 1);
    check("a_run_cnt_clear", a_run_cnt, 0);
    check("a_all_done_clear", a_all_done, 0);
    check("a_sig_clear", a_signature, 0);
    guard = 0;
    while (a_runs < 3 && guard < 300) begin
      step();
      guard++;
    end
    check("a_runs_done", a_runs, 3);
    check("a_idle_start", a_ap_start, 0);
    check("a_idle_busy", a_busy, 0);
    check("a_final_cnt", a_run_cnt, 3);
    check("a_final_all_done", a_all_done, 1);
    start_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (a_ap_start) start_seen = 1;
    end
    check("a_no_4th_start", start_seen, 0);
    check("a_no_4th_run", a_runs, 3);
    a_start_req = 0;
    for (int i = 0; i < 6; i++) step();
    check("a_all_done_sticky", a_all_done, 1);
  endtask

  initial begin
    int guard;
    a_start_req = 0; a_ap_ready = 0; a_ap_done = 0; a_ch_din = '0; a_ch_write = '0;
    b_start_req = 0; b_ap_ready = 0; b_ap_done = 0; b_ch_din = '0; b_ch_write = '0;
    d1_v = 0; d1_d = 0; exp_v = 0; exp_d = 0; exp_sig = 0;
    ap_rst_n = 0;

    // Reset with toggling inputs
    for (int i = 0; i < 5; i++) begin
      a_start_req = 1'($urandom); a_ap_ready = 1'($urandom); a_ap_done = 1'($urandom);
      a_ch_din = {$urandom, $urandom}; a_ch_write = 2'($urandom);
      b_start_req = 1'($urandom); b_ap_ready = 1'($urandom); b_ap_done = 1'($urandom);
      b_ch_din = $urandom; b_ch_write = 1'($urandom);
      step();
      check("rst_a_start", a_ap_start, 0);
      check("rst_a_busy", a_busy, 0);
      check("rst_a_run_cnt", a_run_cnt, 0);
      check("rst_a_all_done", a_all_done, 0);
      check("rst_b_start", b_ap_start, 0);
      check("rst_b_outs", {b_data_out, b_data_valid, b_signature, b_busy, b_all_done}, 0);
      check("rst_b_run_cnt", b_run_cnt, 0);
    end
    a_start_req = 0; a_ap_ready = 0; a_ap_done = 0; a_ch_din = '0; a_ch_write = '0;
    b_start_req = 0; b_ap_ready = 0; b_ap_done = 0; b_ch_din = '0; b_ch_write = '0;
    ap_rst_n = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      check("idle_a_start", a_ap_start, 0);
      check("idle_a_busy", a_busy, 0);
      check("idle_b_busy", b_busy, 0);
    end

    // Directed folds: 0x8, then 0x7 (both channels), then 0xF (ch1 only)
    a_ch_write = 2'b01; a_ch_din = {32'h0, 32'h12345678};
    step();
    a_ch_write = 2'b00; a_ch_din = '0;
    step();
    check("fold1_out", a_data_out, 4'h8);
    check("fold1_valid", a_data_valid, 1);
    step();
    check("fold1_out_after", a_data_out, 0);
    check("fold1_valid_after", a_data_valid, 0);
    check("sig_after_8", a_signature, 4'h8);
    a_ch_write = 2'b11; a_ch_din = {32'h0000000F, 32'h12345678};
    step();
    a_ch_write = 2'b00; a_ch_din = '0;
    step();
    check("fold2_out", a_data_out, 4'h7);
    step();
    check("sig_after_7", a_signature, 4'h6);
    a_ch_write = 2'b10; a_ch_din = {32'h0000000F, 32'h12345678};
    step();
    a_ch_write = 2'b00; a_ch_din = '0;
    step();
    check("fold3_out", a_data_out, 4'hF);
    step();

    // Counted runs with random fold traffic, twice to prove a fresh edge re-arms
    traffic = 1;
    ka_en   = 1;
    run_request_a();
    run_request_a();
    ka_en = 0;

    // Free-running: drop start_req during WAIT of the third run
    kb_en = 1; b_runs = 0; kb_ph = 0;
    b_start_req = 1;
    for (guard = 0; guard < 400; guard++) begin
      step();
      if (b_runs == 2 && kb_ph == 2 && b_start_req) b_start_req = 0;
      if (!b_start_req && kb_ph == 0 && !b_busy) break;
    end
    for (int i = 0; i < 6; i++) step();
    check("b_runs", b_runs, 3);
    check("b_final_cnt", b_run_cnt, 3);
    check("b_all_done", b_all_done, 0);
    check("b_idle_busy", b_busy, 0);
    check("b_idle_start", b_ap_start, 0);
    kb_en = 0;

    // Reset while B sits in START
    b_start_req = 1;
    for (guard = 0; guard < 20 && !b_ap_start; guard++) step();
    check("b_start_seen", b_ap_start, 1);
    ap_rst_n = 0;
    step();
    check("b_rst_start", b_ap_start, 0);
    check("b_rst_busy", b_busy, 0);
    check("b_rst_run_cnt", b_run_cnt, 0);
    check("a_rst_run_cnt", a_run_cnt, 0);
    check("a_rst_all_done", a_all_done, 0);
    ap_rst_n = 1;
    b_start_req = 0;
    traffic = 0;
    a_ch_write = '0;
    for (int i = 0; i < 4; i++) step();
    check("b_post_rst_busy", b_busy, 0);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

endmodule
